// File: rtl/flashing_mode_multi_road_ssm_if.sv
// Supervisor <-> flashing sub-state-machine bundle.
// The supervisor drives the flash request. The sub-SM returns the per-road lamps
// and its status flags.
interface flashing_mode_multi_road_ssm_if #(
    parameter int unsigned NUM_ROADS = 2
);
    logic                     flash_req;
    logic [3*NUM_ROADS-1:0]   lights_ryg;
    logic                     flash_active;
    logic                     flash_phase;
    logic                     exit_done;

    // Supervisory controller side
    modport master (
        output flash_req,
        input  lights_ryg,
        input  flash_active,
        input  flash_phase,
        input  exit_done
    );

    // Flashing sub-state-machine side
    modport slave (
        input  flash_req,
        output lights_ryg,
        output flash_active,
        output flash_phase,
        output exit_done
    );
endinterface

// File: rtl/flashing_mode_multi_road_ssm.sv
// N-road flashing-mode sub-state machine.
// Entry always goes through a timed all-red phase. The lamps then alternate
// between an on half-period and an off half-period. Exit happens only at a
// flash-phase boundary and goes through a timed all-red phase, which ends with
// a one-cycle exit_done pulse.
// Optional build macro FLASHING_SSM_ALTERNATE_PHASE_EN: red-mask roads flash in
// antiphase to the yellow-mask roads instead of in phase with them.
module flashing_mode_multi_road_ssm #(
    parameter int unsigned          NUM_ROADS         = 2,
    parameter int unsigned          TIMER_BITS        = 26,
    parameter int unsigned          ENTRY_RED_COUNT   = 30_000_000,
    parameter int unsigned          FLASH_ON_COUNT    = 5_000_000,
    parameter int unsigned          FLASH_OFF_COUNT   = 5_000_000,
    parameter int unsigned          EXIT_RED_COUNT    = 20_000_000,
    parameter logic [NUM_ROADS-1:0] YELLOW_FLASH_MASK = 'b1
) (
    input logic                           clk_i,
    input logic                           reset_i,
    flashing_mode_multi_road_ssm_if.slave bus_io
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StEntryRed = 3'd1;
    localparam logic [2:0] StFlashOn  = 3'd2;
    localparam logic [2:0] StFlashOff = 3'd3;
    localparam logic [2:0] StExitRed  = 3'd4;

    localparam logic [2:0] LampRed    = 3'b100;
    localparam logic [2:0] LampYellow = 3'b010;
    localparam logic [2:0] LampOff    = 3'b000;

    // Timer reload values: a timed state lasts exactly COUNT cycles.
    localparam logic [TIMER_BITS-1:0] EntryLoad = TIMER_BITS'(ENTRY_RED_COUNT - 1);
    localparam logic [TIMER_BITS-1:0] OnLoad    = TIMER_BITS'(FLASH_ON_COUNT - 1);
    localparam logic [TIMER_BITS-1:0] OffLoad   = TIMER_BITS'(FLASH_OFF_COUNT - 1);
    localparam logic [TIMER_BITS-1:0] ExitLoad  = TIMER_BITS'(EXIT_RED_COUNT - 1);

    localparam logic [3*NUM_ROADS-1:0] AllRed = {NUM_ROADS{LampRed}};

    logic [2:0]             state_q, state_d;
    logic [TIMER_BITS-1:0]  timer_q, timer_d;
    logic [TIMER_BITS-1:0]  timer_dec;
    logic                   timer_done;
    logic [3*NUM_ROADS-1:0] lights_q, lights_d;
    logic                   active_q, active_d;
    logic                   phase_q, phase_d;
    logic                   exit_done_q, exit_done_d;

    // Lamp pattern for a given state; every state other than the two flash
    // phases (including illegal encodings) shows all roads red.
    function automatic logic [3*NUM_ROADS-1:0] lamp_pattern(input logic [2:0] st);
        logic [3*NUM_ROADS-1:0] pat;
        pat = AllRed;
        for (int i = 0; i < int'(NUM_ROADS); i++) begin
            if (st == StFlashOn) begin
`ifdef FLASHING_SSM_ALTERNATE_PHASE_EN
                pat[3*i +: 3] = YELLOW_FLASH_MASK[i] ? LampYellow : LampOff;
`else
                pat[3*i +: 3] = YELLOW_FLASH_MASK[i] ? LampYellow : LampRed;
`endif
            end else if (st == StFlashOff) begin
`ifdef FLASHING_SSM_ALTERNATE_PHASE_EN
                pat[3*i +: 3] = YELLOW_FLASH_MASK[i] ? LampOff : LampRed;
`else
                pat[3*i +: 3] = LampOff;
`endif
            end
        end
        return pat;
    endfunction

    assign timer_done = (timer_q == '0);
    // Saturating decrement so the timer never wraps.
    assign timer_dec  = timer_done ? '0 : timer_q - TIMER_BITS'(1);

    // Next-state and timer reload logic
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_dec;
        exit_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (bus_io.flash_req) begin
                    state_d = StEntryRed;
                    timer_d = EntryLoad;
                end
            end
            StEntryRed: begin
                // Entry can be aborted silently; no lamp has flashed yet.
                if (!bus_io.flash_req) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else if (timer_done) begin
                    state_d = StFlashOn;
                    timer_d = OnLoad;
                end
            end
            StFlashOn: begin
                // flash_req matters only at the end of the phase.
                if (timer_done) begin
                    if (bus_io.flash_req) begin
                        state_d = StFlashOff;
                        timer_d = OffLoad;
                    end else begin
                        state_d = StExitRed;
                        timer_d = ExitLoad;
                    end
                end
            end
            StFlashOff: begin
                if (timer_done) begin
                    if (bus_io.flash_req) begin
                        state_d = StFlashOn;
                        timer_d = OnLoad;
                    end else begin
                        state_d = StExitRed;
                        timer_d = ExitLoad;
                    end
                end
            end
            StExitRed: begin
                // Exit is committed; flash_req is ignored until back in idle.
                if (timer_done) begin
                    state_d     = StIdle;
                    timer_d     = '0;
                    exit_done_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    // Registered outputs are derived from the next state so they move with it.
    always_comb begin
        lights_d = lamp_pattern(state_d);
        active_d = (state_d != StIdle);
        phase_d  = (state_d == StFlashOn);
    end

    // State, timer and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            lights_q    <= AllRed;
            active_q    <= 1'b0;
            phase_q     <= 1'b0;
            exit_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lights_q    <= lights_d;
            active_q    <= active_d;
            phase_q     <= phase_d;
            exit_done_q <= exit_done_d;
        end
    end

    assign bus_io.lights_ryg   = lights_q;
    assign bus_io.flash_active = active_q;
    assign bus_io.flash_phase  = phase_q;
    assign bus_io.exit_done    = exit_done_q;

endmodule

// File: tb/tb_flashing_mode_multi_road_ssm.sv
// Scoreboard bench for the flashing sub-SM.
// The stimulus process drives inputs on the falling edge. It advances a
// phase/elapsed-time reference model and queues the outputs expected after the
// next rising edge. A separate monitor pops the queue and compares the outputs
// 1 time unit after each rising edge.
module tb_flashing_mode_multi_road_ssm;

    localparam int          NR    = 3;
    localparam int          ENTRY = 4;
    localparam int          ON    = 3;
    localparam int          OFF   = 2;
    localparam int          EXIT  = 5;
    localparam logic [NR-1:0] MASK = 3'b001;
`ifdef FLASHING_SSM_ALTERNATE_PHASE_EN
    localparam bit ALT = 1'b1;
`else
    localparam bit ALT = 1'b0;
`endif

    // Reference-model phase names
    localparam int PIdle = 0, PEntry = 1, POn = 2, POff = 3, PExit = 4;

    typedef struct packed {
        logic [3*NR-1:0] lights;
        logic            active;
        logic            phase;
        logic            done;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    bit   mon_en;
    int   checks;
    int   errors;
    int   m_phase;
    int   m_elapsed;
    bit   m_done;

    flashing_mode_multi_road_ssm_if #(.NUM_ROADS(NR)) bus ();

    flashing_mode_multi_road_ssm #(
        .NUM_ROADS         (NR),
        .TIMER_BITS        (8),
        .ENTRY_RED_COUNT   (ENTRY),
        .FLASH_ON_COUNT    (ON),
        .FLASH_OFF_COUNT   (OFF),
        .EXIT_RED_COUNT    (EXIT),
        .YELLOW_FLASH_MASK (MASK)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus_io  (bus)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Lamp shown by one road in a given phase
    function automatic logic [2:0] road_lamp(input int ph, input bit yellow);
        if (ph == POn)  return yellow ? 3'b010 : (ALT ? 3'b000 : 3'b100);
        if (ph == POff) return (ALT && !yellow) ? 3'b100 : 3'b000;
        return 3'b100;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int r = 0; r < NR; r++) e.lights[3*r +: 3] = road_lamp(m_phase, MASK[r]);
        e.active = (m_phase != PIdle);
        e.phase  = (m_phase == POn);
        e.done   = m_done;
        return e;
    endfunction

    // Advance the model by one clock: count elapsed cycles in the current phase
    // and move on when the phase has run for its full duration.
    task automatic model_step(input bit req, input bit rst);
        m_done = 1'b0;
        if (rst) begin
            m_phase   = PIdle;
            m_elapsed = 0;
        end else begin
            case (m_phase)
                PIdle: if (req) begin m_phase = PEntry; m_elapsed = 0; end
                PEntry: begin
                    if (!req) begin m_phase = PIdle; m_elapsed = 0; end
                    else if (m_elapsed + 1 == ENTRY) begin m_phase = POn; m_elapsed = 0; end
                    else m_elapsed++;
                end
                POn: begin
                    if (m_elapsed + 1 == ON) begin
                        m_phase = req ? POff : PExit; m_elapsed = 0;
                    end else m_elapsed++;
                end
                POff: begin
                    if (m_elapsed + 1 == OFF) begin
                        m_phase = req ? POn : PExit; m_elapsed = 0;
                    end else m_elapsed++;
                end
                default: begin
                    if (m_elapsed + 1 == EXIT) begin
                        m_phase = PIdle; m_elapsed = 0; m_done = 1'b1;
                    end else m_elapsed++;
                end
            endcase
        end
    endtask

    // One clock of stimulus: set inputs, predict, queue the expectation
    task automatic drive(input bit req, input bit rst);
        @(negedge clk);
        bus.flash_req = req;
        reset         = rst;
        model_step(req, rst);
        exp_q.push_back(model_out());
        mon_en = 1'b1;
    endtask

    task automatic hold(input bit req, input int n);
        for (int k = 0; k < n; k++) drive(req, 1'b0);
    endtask

    // Monitor: compare the DUT outputs with the oldest queued expectation
    initial begin
        exp_t act;
        exp_t exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                act = '{lights: bus.lights_ryg, active: bus.flash_active,
                        phase: bus.flash_phase, done: bus.exit_done};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty t=%0t got=%h required=queued entry", $time, act);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act !== exp_v) begin
                        errors++;
                        $display("FAIL outputs t=%0t got lights=%b act=%b ph=%b done=%b required lights=%b act=%b ph=%b done=%b",
                                 $time, act.lights, act.active, act.phase, act.done,
                                 exp_v.lights, exp_v.active, exp_v.phase, exp_v.done);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        checks        = 0;
        errors        = 0;
        mon_en        = 1'b0;
        m_phase       = PIdle;
        m_elapsed     = 0;
        m_done        = 1'b0;
        bus.flash_req = 1'b0;
        reset         = 1'b1;

        // Reset, then idle with no request
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        hold(1'b0, 20);

        // Enter, flash for several periods, then drop the request mid-phase
        hold(1'b1, 20);
        hold(1'b0, 15);

        // Abort entry on its second cycle
        hold(1'b1, 2);
        hold(1'b0, 3);

        // Request pulsed during exit, then held so idle re-enters entry
        hold(1'b1, ENTRY + 1);
        hold(1'b0, 4);
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 8);
        hold(1'b0, 20);

        // Reset while in the flash-off phase
        guard = 0;
        while (m_phase != POff && guard < 50) begin
            drive(1'b1, 1'b0);
            guard++;
        end
        drive(1'b1, 1'b1);
        hold(1'b0, 3);

        // Random request and occasional reset
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 63) == 0));
        end
        hold(1'b0, 20);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d left required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
